// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the SLC3 debug register-dump transmitter.
package slc3_dbg_pkg;
    localparam int unsigned DATA_BITS = 16;
    localparam int unsigned REG_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        START_B,
        DATA_B,
        STOP_B,
        FIN
    } dump_state_t;
endpackage

// File: rtl/reg_dump_tx_if.sv
// Request, register-file read port and serial output of the dump transmitter.
interface reg_dump_tx_if;
    import slc3_dbg_pkg::*;

    logic                 Start;
    logic                 ONE_REG;
    logic [REG_IDX_W-1:0] REG_ID;
    logic [DATA_BITS-1:0] RD_DATA;
    logic [REG_IDX_W-1:0] RD_SEL;
    logic                 TX;
    logic                 Busy;
    logic                 Done;

    modport master (
        output Start, ONE_REG, REG_ID, RD_DATA,
        input  RD_SEL, TX, Busy, Done
    );

    modport slave (
        input  Start, ONE_REG, REG_ID, RD_DATA,
        output RD_SEL, TX, Busy, Done
    );
endinterface

// File: rtl/reg_dump_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1, ticks on the last count, wraps.
module bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(BIT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/reg_dump_tx.sv
// Walks the register file through its SR2 read port and serializes each value
// as start bit, 16 data bits LSB first, stop bit.
import slc3_dbg_pkg::*;

module reg_dump_tx #(
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic Clk,
    input  logic Reset,
    reg_dump_tx_if.slave bus
);
    dump_state_t          state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q;
    logic                 one_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bit_cnt_q;
    logic                 tick;
    logic                 last_reg;

    // Timer restarts on every state change so each bit period starts aligned.
    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (state_d != state_q),
        .tick  (tick)
    );

    assign last_reg   = one_q || (idx_q == REG_IDX_W'(NUM_REGS - 1));
    assign bus.RD_SEL = idx_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.TX   = 1'b1;
        bus.Busy = 1'b1;
        bus.Done = 1'b0;
        case (state_q)
            IDLE: begin
                bus.Busy = 1'b0;
                if (bus.Start) state_d = ADDR;
            end
            ADDR: state_d = CAPT;
            CAPT: state_d = START_B;
            START_B: begin
                bus.TX = 1'b0;
                if (tick) state_d = DATA_B;
            end
            DATA_B: begin
                bus.TX = shift_q[0];
                if (tick && bit_cnt_q == 4'd15) state_d = STOP_B;
            end
            STOP_B: begin
                if (tick) state_d = last_reg ? FIN : ADDR;
            end
            FIN: begin
                bus.Done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx_q     <= '0;
            one_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        one_q <= bus.ONE_REG;
                        idx_q <= bus.ONE_REG ? bus.REG_ID : '0;
                    end
                end
                CAPT: begin
                    shift_q   <= bus.RD_DATA;
                    bit_cnt_q <= '0;
                end
                DATA_B: begin
                    if (tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                STOP_B: begin
                    if (tick && !last_reg) idx_q <= idx_q + REG_IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: register-file model, serial decoder and frame scoreboard.
module tb_reg_dump_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_dump_tx_if bus();

    reg_dump_tx #(.BIT_CYCLES(4), .NUM_REGS(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [15:0] rf [8];
    logic [15:0] model [8];
    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;

    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
        bus.RD_DATA <= rf[bus.RD_SEL];
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Serial decoder: samples each bit in its third cycle, pops the scoreboard.
    int          rx_cnt = 0;
    bit          rx_active = 1'b0;
    int          rx_frames = 0;
    logic [15:0] rx_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (bus.TX === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 2) begin
                chk("start_bit", 32'(bus.TX), 32'd0);
            end else if (rx_cnt >= 6 && rx_cnt <= 66 && ((rx_cnt - 6) % 4) == 0) begin
                rx_word[(rx_cnt - 6) / 4] = bus.TX;
            end else if (rx_cnt == 70) begin
                chk("stop_bit", 32'(bus.TX), 32'd1);
                rx_active = 1'b0;
                rx_frames++;
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_frame: got %04h expected no frame", rx_word);
                end else begin
                    chk("frame_data", 32'(rx_word), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_regs(input logic [15:0] r0, input logic [15:0] r3);
        for (int unsigned k = 0; k < 8; k++) begin
            model[k] = (k == 0) ? r0 : (k == 3) ? r3 : 16'(16'h1111 * k);
            we = 1'b1;
            wa = 3'(k);
            wd = model[k];
            step();
        end
        we = 1'b0;
    endtask

    task automatic push_expected(input bit one, input logic [2:0] id);
        if (one) sb.push_back(model[id]);
        else for (int k = 0; k < 8; k++) sb.push_back(model[k]);
    endtask

    task automatic run_dump(input bit one, input logic [2:0] id, input bit repulse,
                            input int wr_cyc, input int exp_cycles, input int exp_frames);
        int busy_n = 0, done_n = 0, done_at = 0, sel_err = 0, frames0;
        logic [2:0] exp_sel;
        frames0 = rx_frames;
        push_expected(one, id);
        bus.ONE_REG = one;
        bus.REG_ID  = id;
        bus.Start   = 1'b1;
        for (int cyc = 1; cyc <= exp_cycles + 6; cyc++) begin
            step();
            bus.Start = 1'b0;
            we = 1'b0;
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            if (one) exp_sel = id;
            else if (cyc <= 592) exp_sel = 3'((cyc - 1) / 74);
            else exp_sel = 3'd7;
            if (bus.RD_SEL !== exp_sel) sel_err++;
            if (repulse && (cyc == exp_cycles / 2 || cyc == exp_cycles)) bus.Start = 1'b1;
            if (cyc == wr_cyc) begin
                we = 1'b1;
                wa = '0;
                wd = 16'hFFFF;
            end
        end
        chk("busy_cycles", busy_n, exp_cycles);
        chk("done_count", done_n, 1);
        chk("done_cycle", done_at, exp_cycles);
        chk("rd_sel_track", sel_err, 0);
        chk("frame_count", rx_frames - frames0, exp_frames);
        chk("sb_drained", sb.size(), 0);
    endtask

    typedef struct {
        bit          one;
        logic [2:0]  id;
        bit          repulse;
        int          wr_cyc;
        logic [15:0] r0;
        logic [15:0] r3;
        int          exp_cycles;
        int          exp_frames;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int busy_n, done_n, frames0;
        vecs[0] = '{1'b1, 3'd3, 1'b0, 0, 16'h0000, 16'hA5C3, 75, 1};
        vecs[1] = '{1'b0, 3'd0, 1'b0, 0, 16'h0000, 16'h3333, 593, 8};
        vecs[2] = '{1'b0, 3'd5, 1'b1, 0, 16'h0000, 16'h3333, 593, 8};
        vecs[3] = '{1'b1, 3'd0, 1'b0, 4, 16'h0F0F, 16'h3333, 75, 1};
        vecs[4] = '{1'b1, 3'd7, 1'b1, 0, 16'h0000, 16'h3333, 75, 1};

        bus.Start = 1'b0;
        bus.ONE_REG = 1'b0;
        bus.REG_ID = '0;
        repeat (3) step();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_tx", 32'(bus.TX), 32'd1);
            chk("idle_busy", 32'(bus.Busy), 32'd0);
            chk("idle_done", 32'(bus.Done), 32'd0);
            chk("idle_rd_sel", 32'(bus.RD_SEL), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            load_regs(vecs[i].r0, vecs[i].r3);
            run_dump(vecs[i].one, vecs[i].id, vecs[i].repulse, vecs[i].wr_cyc,
                     vecs[i].exp_cycles, vecs[i].exp_frames);
        end

        // Reset during bit 5 of the R2 frame (cycles 175..178 after Start).
        load_regs(16'h0000, 16'h3333);
        frames0 = rx_frames;
        done_n = 0;
        push_expected(1'b0, 3'd0);
        bus.ONE_REG = 1'b0;
        bus.Start = 1'b1;
        for (int cyc = 1; cyc <= 176; cyc++) begin
            step();
            bus.Start = 1'b0;
            if (bus.Done) done_n++;
        end
        chk("pre_reset_tx_bit5", 32'(bus.TX), 32'(model[2][5]));
        rst = 1'b1;
        step();
        chk("abort_tx", 32'(bus.TX), 32'd1);
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_rd_sel", 32'(bus.RD_SEL), 32'd0);
        rst = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.Done) done_n++;
            if (bus.Busy) busy_n++;
        end
        chk("abort_no_done", done_n, 0);
        chk("abort_stays_idle", busy_n, 0);
        chk("abort_frames", rx_frames - frames0, 2);
        chk("abort_pending", sb.size(), 6);
        sb.delete();
        run_dump(1'b0, 3'd0, 1'b0, 0, 593, 8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
